median_window_pipe: RTL and testbench



---
 rtl/median_pkg.sv | 26 ++
 rtl/median_cmp_swap.sv | 26 ++
 rtl/median_window_pipe.sv | 164 ++++++++++++++++
 tb/tb_median_window_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants, handshake state type and index helpers for the
// sliding-window median filter.
package median_pkg;

    // Largest supported window length and the fill counter width it needs.
    localparam int MEDIAN_MAX_WINDOW = 15;
    localparam int MEDIAN_CNT_W      = 4;

    // Priming: fewer than WINDOW-1 samples held, an accept cannot launch.
    // Streaming: window holds WINDOW-1 samples, every accept launches.
    typedef enum logic [0:0] {
        HS_PRIMING   = 1'b0,
        HS_STREAMING = 1'b1
    } median_hs_e;

    // Position of the median in a sorted window of odd length.
    function automatic int median_idx(input int window);
        return window / 2;
    endfunction

    // Odd stages pair (0,1),(2,3)...; even stages pair (1,2),(3,4)...
    function automatic bit is_odd_stage(input int k);
        return (k % 2) == 1;
    endfunction

endpackage

// File: rtl/median_cmp_swap.sv
// Combinational compare-exchange cell: the smaller operand leaves on lo,
// the larger on hi. Equal operands pass straight through (no swap).
module median_cmp_swap #(
    parameter int DATA_WIDTH  = 8,
    parameter int SIGNED_DATA = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    logic greater;

    generate
        if (SIGNED_DATA != 0) begin : g_signed
            assign greater = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign greater = a > b;
        end
    endgenerate

    assign lo = greater ? b : a;
    assign hi = greater ? a : b;

endmodule

// File: rtl/median_window_pipe.sv
// Streaming sliding-window median filter. A WINDOW-entry shift register
// collects samples; once it is full, every accepted sample launches the
// whole window into a WINDOW-stage odd-even transposition sorter, and the
// middle element of the last stage is the output.
//
// Valid/ready: a transfer happens on any edge where valid and ready are both
// high. Upstream sees s_ready = en & !flush & !rst, where en = !m_valid |
// m_ready; when the output is held (m_valid & !m_ready) the window, the fill
// counter and every pipeline stage freeze. flush restarts priming and drops
// everything in flight, including a held output.
//
// Optional build macro MEDIAN_MINMAX_EN: adds m_min/m_max, the first and last
// elements of the final sorted stage, registered and stalled with m_data.
module median_window_pipe
    import median_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW      = 5,
    parameter int SIGNED_DATA = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
`ifdef MEDIAN_MINMAX_EN
    output logic [DATA_WIDTH-1:0] m_min,
    output logic [DATA_WIDTH-1:0] m_max,
`endif
    input  logic                  m_ready
);

    localparam int MID = median_idx(WINDOW);
    localparam logic [MEDIAN_CNT_W-1:0] FULL_CNT = MEDIAN_CNT_W'(WINDOW - 1);
    localparam logic [MEDIAN_CNT_W-1:0] LAST_PRIME_CNT = MEDIAN_CNT_W'(WINDOW - 2);

    generate
        if (WINDOW < 3 || WINDOW > MEDIAN_MAX_WINDOW || (WINDOW % 2) == 0) begin : g_bad_window
            $error("median_window_pipe: WINDOW must be odd and within 3..15");
        end
        if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
            $error("median_window_pipe: DATA_WIDTH must be within 2..32");
        end
    endgenerate

    logic                     en;
    logic                     accept;
    logic                     launch;
    logic [MEDIAN_CNT_W-1:0]  fill_cnt;
    median_hs_e               hs_state;

    logic [DATA_WIDTH-1:0]    window_q    [WINDOW];
    logic [DATA_WIDTH-1:0]    window_next [WINDOW];

    logic [DATA_WIDTH-1:0]    stage_in  [1:WINDOW][WINDOW];
    logic [DATA_WIDTH-1:0]    stage_out [1:WINDOW][WINDOW];
    logic [DATA_WIDTH-1:0]    stage_q   [1:WINDOW][WINDOW];
    logic [WINDOW:1]          stage_valid;

    assign m_valid = stage_valid[WINDOW];
    assign en      = !m_valid | m_ready;
    assign s_ready = en & !flush & !rst;
    assign accept  = s_valid & s_ready;
    assign launch  = accept & (hs_state == HS_STREAMING);

    // Window after shifting the incoming sample in at index 0.
    always_comb begin
        window_next[0] = s_data;
        for (int i = 1; i < WINDOW; i++) begin
            window_next[i] = window_q[i-1];
        end
    end

    // Sorter network: stage 1 sorts the freshly shifted window, later stages
    // continue on the previous stage's registers.
    generate
        for (genvar k = 1; k <= WINDOW; k++) begin : g_stage
            localparam int FIRST = is_odd_stage(k) ? 0 : 1;

            for (genvar i = 0; i < WINDOW; i++) begin : g_in
                if (k == 1) begin : g_from_window
                    assign stage_in[k][i] = window_next[i];
                end else begin : g_from_stage
                    assign stage_in[k][i] = stage_q[k-1][i];
                end
            end

            for (genvar i = 0; i < WINDOW; i++) begin : g_cell
                if (i >= FIRST && ((i - FIRST) % 2) == 0 && (i + 1) < WINDOW) begin : g_cx
                    median_cmp_swap #(
                        .DATA_WIDTH  (DATA_WIDTH),
                        .SIGNED_DATA (SIGNED_DATA)
                    ) u_cmp_swap (
                        .a  (stage_in[k][i]),
                        .b  (stage_in[k][i+1]),
                        .lo (stage_out[k][i]),
                        .hi (stage_out[k][i+1])
                    );
                end else if (!((i - 1) >= FIRST && ((i - 1 - FIRST) % 2) == 0)) begin : g_pass
                    // Unpaired edge element rides through this stage untouched.
                    assign stage_out[k][i] = stage_in[k][i];
                end
            end
        end
    endgenerate

    // Handshake state, fill counter and the valid bits travelling with data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt    <= '0;
            hs_state    <= HS_PRIMING;
            stage_valid <= '0;
        end else if (flush) begin
            fill_cnt    <= '0;
            hs_state    <= HS_PRIMING;
            stage_valid <= '0;
        end else if (en) begin
            if (accept) begin
                if (fill_cnt != FULL_CNT) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                hs_state <= (fill_cnt >= LAST_PRIME_CNT) ? HS_STREAMING : HS_PRIMING;
            end
            stage_valid[1]        <= launch;
            stage_valid[WINDOW:2] <= stage_valid[WINDOW-1:1];
        end
    end

    // Window and stage data; frozen under backpressure or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                window_q[i] <= '0;
            end
            for (int k = 1; k <= WINDOW; k++) begin
                for (int i = 0; i < WINDOW; i++) begin
                    stage_q[k][i] <= '0;
                end
            end
        end else if (en && !flush) begin
            if (accept) begin
                for (int i = 0; i < WINDOW; i++) begin
                    window_q[i] <= window_next[i];
                end
            end
            for (int k = 1; k <= WINDOW; k++) begin
                for (int i = 0; i < WINDOW; i++) begin
                    stage_q[k][i] <= stage_out[k][i];
                end
            end
        end
    end

    assign m_data = stage_q[WINDOW][MID];

`ifdef MEDIAN_MINMAX_EN
    assign m_min = stage_q[WINDOW][0];
    assign m_max = stage_q[WINDOW][WINDOW-1];
`endif

endmodule

// File: tb/tb_median_window_pipe.sv
// Directed bench for median_window_pipe (WINDOW=5, DATA_WIDTH=8). A second
// instance with SIGNED_DATA=1 shares the stimulus for the signed case.
module tb_median_window_pipe;

    localparam int DW  = 8;
    localparam int WIN = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          m_ready;

    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          sgn_s_ready;
    logic [DW-1:0] sgn_m_data;
    logic          sgn_m_valid;
`ifdef MEDIAN_MINMAX_EN
    logic [DW-1:0] m_min;
    logic [DW-1:0] m_max;
    logic [DW-1:0] sgn_m_min;
    logic [DW-1:0] sgn_m_max;
`endif

    median_window_pipe #(.DATA_WIDTH(DW), .WINDOW(WIN), .SIGNED_DATA(0)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
`ifdef MEDIAN_MINMAX_EN
        .m_min   (m_min),
        .m_max   (m_max),
`endif
        .m_ready (m_ready)
    );

    median_window_pipe #(.DATA_WIDTH(DW), .WINDOW(WIN), .SIGNED_DATA(1)) u_dut_signed (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (sgn_s_ready),
        .m_data  (sgn_m_data),
        .m_valid (sgn_m_valid),
`ifdef MEDIAN_MINMAX_EN
        .m_min   (sgn_m_min),
        .m_max   (sgn_m_max),
`endif
        .m_ready (m_ready)
    );

    // ---------------- scoreboard ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    int out_cnt      = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every completed output transfer is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, m_valid}, 32'd0);
            end else begin
                check("out_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge+1.
    task automatic send(input logic [DW-1:0] d);
        bit done;
        done    = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic send_list(input logic [DW-1:0] v[$]);
        foreach (v[i]) send(v[i]);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 80 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        repeat (WIN + 3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        out_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] vec[$];

        // Reset state.
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data",  {24'd0, m_data}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_s_ready", {31'd0, s_ready}, 32'd1);
        check("rel_sgn_s_ready", {31'd0, sgn_s_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic medians and latency: windows {10,200,30,40,50}, {200,30,40,50,60},
        // {30,40,50,60,5}.
        exp_q = '{8'd40, 8'd50, 8'd40};
        out_cnt = 0;
        vec = '{8'd10, 8'd200, 8'd30, 8'd40};
        send_list(vec);
        send(8'd50);
        s_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("lat_early", {31'd0, m_valid}, 32'd0);
        end
        @(negedge clk);
        check("lat_valid", {31'd0, m_valid}, 32'd1);
        check("lat_data", {24'd0, m_data}, 32'd40);
`ifdef MEDIAN_MINMAX_EN
        check("lat_min", {24'd0, m_min}, 32'd10);
        check("lat_max", {24'd0, m_max}, 32'd200);
`endif
        @(posedge clk); #1;
        vec = '{8'd60, 8'd5};
        send_list(vec);
        drain();
        check("basic_cnt", out_cnt, 32'd3);

        // Impulse rejection: the 255 spike never reaches the output.
        do_reset();
        exp_q = '{8'd20, 8'd20, 8'd20, 8'd20};
        vec = '{8'd20, 8'd20, 8'd255, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20};
        send_list(vec);
        drain();
        check("impulse_cnt", out_cnt, 32'd4);

        // Backpressure: output held while m_ready=0, no loss or duplication.
        do_reset();
        m_ready = 1'b0;
        exp_q = '{8'd50, 8'd30, 8'd70, 8'd40, 8'd60, 8'd40, 8'd60};
        vec = '{8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60, 8'd15, 8'd95};
        fork
            begin : bp_sender
                send_list(vec);
            end
            begin : bp_stall
                bit seen;
                logic [DW-1:0] held;
                seen = 1'b0;
                for (int w = 0; w < 80 && !seen; w++) begin
                    @(negedge clk);
                    if (m_valid) seen = 1'b1;
                end
                check("bp_seen", {31'd0, seen}, 32'd1);
                held = m_data;
                repeat (3) begin
                    @(negedge clk);
                    check("bp_s_ready", {31'd0, s_ready}, 32'd0);
                    check("bp_m_valid", {31'd0, m_valid}, 32'd1);
                    check("bp_hold", {24'd0, m_data}, {24'd0, held});
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain();
        check("bp_cnt", out_cnt, 32'd7);

        // Flush with a simultaneous sample: sample dropped, priming restarts.
        do_reset();
        vec = '{8'd1, 8'd2, 8'd3};
        send_list(vec);
        flush = 1'b1; s_valid = 1'b1; s_data = 8'd99;
        @(negedge clk);
        check("flush_s_ready", {31'd0, s_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; s_valid = 1'b0;
        vec = '{8'd11, 8'd44, 8'd22, 8'd55};
        send_list(vec);
        repeat (8) @(negedge clk);
        check("flush_no_early", out_cnt, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back(8'd33);
        send(8'd33);
        s_valid = 1'b0;
        drain();
        check("flush_cnt", out_cnt, 32'd1);

        // Signedness: same bytes, unsigned median 0x07, signed median 0x00.
        do_reset();
        exp_q.push_back(8'h07);
        vec = '{8'hFD, 8'h07, 8'h80, 8'h00, 8'h05};
        send_list(vec);
        for (int w = 0; w < 40 && !m_valid; w++) @(negedge clk);
        check("sgn_valid", {31'd0, sgn_m_valid}, 32'd1);
        check("sgn_data", {24'd0, sgn_m_data}, 32'd0);
`ifdef MEDIAN_MINMAX_EN
        check("sgn_min", {24'd0, sgn_m_min}, 32'h80);
        check("sgn_max", {24'd0, sgn_m_max}, 32'h07);
        check("uns_max", {24'd0, m_max}, 32'hFD);
`endif
        @(posedge clk); #1;
        drain();

        // Reset with three results in flight, then a fresh priming.
        do_reset();
        vec = '{8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd20, 8'd80};
        send_list(vec);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_data", {24'd0, m_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_cnt = 0;
        vec = '{8'd7, 8'd1, 8'd9, 8'd3};
        send_list(vec);
        repeat (10) @(negedge clk);
        check("midrst_noout", out_cnt, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back(8'd5);
        send(8'd5);
        s_valid = 1'b0;
        drain();
        check("midrst_cnt", out_cnt, 32'd1);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
